// File: rtl/layer_sched_if.sv
// Handshake bundle between layer_scheduler, the input buffer, the bit-serial
// datapath and the downstream result consumer.
// master: the scheduler side. slave: the buffer/datapath/consumer side.
interface layer_sched_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_OUT  = 4
);
  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam int unsigned NIDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic              vec_done;
  logic              buf_busy;
  logic              vec_latch;
  logic              acc_clr;
  logic              bit_en;
  logic [BIT_W-1:0]  bit_idx;
  logic              msb_flag;
  logic [NIDX_W-1:0] neuron_idx;
  logic              res_valid;
  logic              res_ready;
  logic              layer_done;
  logic              ovr_err;

  modport master (
    input  vec_done, res_ready,
    output buf_busy, vec_latch, acc_clr, bit_en, bit_idx, msb_flag,
           neuron_idx, res_valid, layer_done, ovr_err
  );

  modport slave (
    output vec_done, res_ready,
    input  buf_busy, vec_latch, acc_clr, bit_en, bit_idx, msb_flag,
           neuron_idx, res_valid, layer_done, ovr_err
  );
endinterface

// File: rtl/layer_scheduler.sv
// Layer scheduler for a bit-serial neuron datapath.
// For each captured input vector it evaluates N_OUT neurons in turn: clear the
// accumulator, stream DATA_W bit-planes LSB first (sign plane flagged), then
// hand the result downstream with a valid/ready handshake.
// Optional macro LAYER_SCHED_PERF_CNT_EN adds 32-bit layer and stall counters.
module layer_scheduler #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_OUT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  layer_sched_if.master bus
`ifdef LAYER_SCHED_PERF_CNT_EN
  ,
  output logic [31:0] perf_layer_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam int unsigned NIDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [BIT_W-1:0]  BitLast    = BIT_W'(DATA_W - 1);
  localparam logic [NIDX_W-1:0] NeuronLast = NIDX_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StClear,
    StShift,
    StResult
  } state_e;

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [NIDX_W-1:0] neuron_q, neuron_d;
  logic              layer_done_q, layer_done_d;
  logic              ovr_err_q, ovr_err_d;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_q        <= '0;
      neuron_q     <= '0;
      layer_done_q <= 1'b0;
      ovr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      neuron_q     <= neuron_d;
      layer_done_q <= layer_done_d;
      ovr_err_q    <= ovr_err_d;
    end
  end

  // Next-state sequencing; counters park at 0 outside their active window.
  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    neuron_d     = neuron_q;
    layer_done_d = 1'b0;
    // A vector arriving while busy is dropped for sequencing but remembered.
    ovr_err_d    = ovr_err_q | (bus.vec_done && (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (bus.vec_done) state_d = StLatch;
      end
      StLatch: begin
        neuron_d = '0;
        state_d  = StClear;
      end
      StClear: begin
        bit_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (bit_q == BitLast) begin
          bit_d   = '0;
          state_d = StResult;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      StResult: begin
        if (bus.res_ready) begin
          if (neuron_q == NeuronLast) begin
            neuron_d     = '0;
            layer_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            neuron_d = neuron_q + 1'b1;
            state_d  = StClear;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode from registered state and counters.
  always_comb begin
    bus.buf_busy   = (state_q != StIdle);
    bus.vec_latch  = (state_q == StLatch);
    bus.acc_clr    = (state_q == StClear);
    bus.bit_en     = (state_q == StShift);
    bus.bit_idx    = bit_q;
    bus.msb_flag   = (state_q == StShift) && (bit_q == BitLast);
    bus.neuron_idx = neuron_q;
    bus.res_valid  = (state_q == StResult);
    bus.layer_done = layer_done_q;
    bus.ovr_err    = ovr_err_q;
  end

`ifdef LAYER_SCHED_PERF_CNT_EN
  logic [31:0] layer_cnt_q, stall_cnt_q;

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (layer_done_q) layer_cnt_q <= layer_cnt_q + 32'd1;
      if ((state_q == StResult) && !bus.res_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_layer_cnt = layer_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
